// File: rtl/sbox_layer_seq.sv
// sbox_layer_seq: multi-cycle 4-bit S-box substitution layer for a
// PRESENT-style block cipher datapath.
//
// A block is accepted in IDLE, substituted LANES nibbles per cycle (least
// significant nibble group first) in BUSY, then presented in DONE until the
// downstream stage takes it.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   input block valid
//   in_ready   block can be accepted (IDLE only)
//   in_data    block to substitute
//   in_inverse 0 = forward S-box, 1 = inverse S-box; sampled with in_data
//   out_valid  result valid (DONE only)
//   out_ready  downstream accepts result
//   out_data   substituted block, zero outside DONE
//   busy       high in BUSY and DONE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a block, in_ready high
// BUSY  | substituting nibble group cnt, one group per cycle
// DONE  | result presented on out_data, waiting for out_ready
module sbox_layer_seq #(
   parameter int STATE_BITS = 64,
   parameter int LANES      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [STATE_BITS-1:0] in_data,
   input  logic                  in_inverse,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [STATE_BITS-1:0] out_data,
   output logic                  busy
);

   localparam int NIBS  = STATE_BITS / 4;
   localparam int STEPS = STATE_BITS / (4 * LANES);
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [STATE_BITS-1:0]   work_q, work_d;
   logic [STATE_BITS-1:0]   out_data_q, out_data_d;
   logic [STATE_BITS-1:0]   sub_data;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    inv_q, inv_d;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;
   logic                    busy_q, busy_d;

   function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
         4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
         4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
         4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
      endcase
      return y;
   endfunction

   function automatic logic [3:0] sbox_inv(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
         4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
         4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
         4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
      endcase
      return y;
   endfunction

   // Nibble k belongs to group k/LANES; only the group selected by cnt is
   // replaced, so the loop resolves to LANES muxed S-box lookups per group.
   always_comb begin
      sub_data = work_q;
      for (int k = 0; k < NIBS; k++) begin
         if ((k / LANES) == int'(cnt_q)) begin
            sub_data[4*k +: 4] = inv_q ? sbox_inv(work_q[4*k +: 4])
                                       : sbox_fwd(work_q[4*k +: 4]);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      out_data_d  = out_data_q;
      cnt_d       = cnt_q;
      inv_d       = inv_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               work_d     = in_data;
               inv_d      = in_inverse;
               cnt_d      = '0;
               state_d    = S_BUSY;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         S_BUSY: begin
            work_d = sub_data;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d     = S_DONE;
               out_valid_d = 1'b1;
               out_data_d  = sub_data;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
               out_data_d  = '0;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         work_q      <= '0;
         out_data_q  <= '0;
         cnt_q       <= '0;
         inv_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         out_data_q  <= out_data_d;
         cnt_q       <= cnt_d;
         inv_q       <= inv_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;

endmodule
